// File: rtl/count_capture_pkg.sv
// Shared encodings for the count capture stage: edge select codes, arming states
// and the edge qualification helper.
package count_capture_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    localparam logic [0:0] ARMING = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    function automatic logic edge_qualify(input logic [1:0] sel, input logic rise,
                                          input logic fall);
        logic hit;
        case (sel)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Show-ahead FIFO holding captured count values; a write while full is only
// accepted when a pop happens on the same edge.
module capture_fifo
    import count_capture_pkg::*;
#(
    parameter int unsigned W     = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          do_wr, do_rd;

    always_comb begin
        empty = (level_q == '0);
        full  = (level_q == LW'(DEPTH));
        do_rd = rd_en & ~empty;
        do_wr = wr_en & (~full | do_rd);
        rd_data = empty ? '0 : mem[rd_ptr_q];
        level = level_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage is not cleared; an empty FIFO masks its output instead.
    always_ff @(posedge clk) begin
        if (reset && do_wr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/count_capture.sv
// Input capture: synchronises an async event line, detects selected edges once
// armed, and snapshots the count bus into a show-ahead FIFO.
module count_capture
    import count_capture_pkg::*;
#(
    parameter int unsigned W           = 24,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [W-1:0]             count_in,
    input  logic                     evt_in,
    input  logic [1:0]               edge_sel,
    input  logic                     rd_en,
    input  logic                     clr_ovf,
    output logic [W-1:0]             cap_data,
    output logic                     cap_valid,
    output logic [$clog2(DEPTH):0]   cap_level,
    output logic                     overflow,
    output logic                     event_pulse
);

    localparam int unsigned CntW = $clog2(SYNC_STAGES + 2);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [0:0]             state_q;
    logic [CntW-1:0]        arm_cnt_q;
    logic                   pulse_q;
    logic                   ovf_q;
    logic                   sync_last, rise, fall, qual, drop;
    logic                   fifo_full, fifo_empty;

    always_comb begin
        sync_last = sync_q[SYNC_STAGES-1];
        rise      = sync_last & ~hist_q;
        fall      = ~sync_last & hist_q;
        qual      = (state_q == ACTIVE) & edge_qualify(edge_sel, rise, fall);
        // A pop on the same edge frees a slot, so only an unserviced full write drops.
        drop      = qual & fifo_full & ~rd_en;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            pulse_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], evt_in};
            hist_q  <= sync_last;
            pulse_q <= qual;
            if (drop)         ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
        end
    end

    // Hold off edge detection until the sync chain and history reflect evt_in.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ARMING;
            arm_cnt_q <= '0;
        end else if (state_q == ARMING) begin
            arm_cnt_q <= arm_cnt_q + 1'b1;
            if (arm_cnt_q == CntW'(SYNC_STAGES)) state_q <= ACTIVE;
        end
    end

    capture_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (qual),
        .wr_data (count_in),
        .rd_en   (rd_en),
        .rd_data (cap_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (cap_level)
    );

    assign cap_valid   = ~fifo_empty;
    assign overflow    = ovf_q;
    assign event_pulse = pulse_q;

endmodule

// File: tb/tb_count_capture.sv
// Directed bench for count_capture: latency, both-edge capture, overflow,
// full-with-read, arming after reset and mid-operation reset.
module tb_count_capture;

    logic        clk;
    logic        reset;
    logic [23:0] count_in;
    logic        evt_in;
    logic [1:0]  edge_sel;
    logic        rd_en;
    logic        clr_ovf;
    logic [23:0] cap_data;
    logic        cap_valid;
    logic [2:0]  cap_level;
    logic        overflow;
    logic        event_pulse;

    int checks = 0;
    int errors = 0;
    logic [23:0] vals [0:4];
    logic [23:0] newv;

    count_capture #(
        .W           (24),
        .DEPTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .count_in    (count_in),
        .evt_in      (evt_in),
        .edge_sel    (edge_sel),
        .rd_en       (rd_en),
        .clr_ovf     (clr_ovf),
        .cap_data    (cap_data),
        .cap_valid   (cap_valid),
        .cap_level   (cap_level),
        .overflow    (overflow),
        .event_pulse (event_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; the counter ramps by one right after each edge.
    task automatic tick();
        @(posedge clk);
        #1;
        count_in = count_in + 24'd1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (cap_valid !== 1'b0 || cap_level !== 3'd0 || cap_data !== 24'd0 ||
            overflow !== 1'b0 || event_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b level=%0d data=%h ovf=%b pulse=%b want all 0",
                     cap_valid, cap_level, cap_data, overflow, event_pulse);
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_latency();
        count_in = 24'h000100;
        evt_in   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (event_pulse !== 1'b0) begin
                errors++;
                $display("FAIL latency_early: cycle %0d pulse=%b want 0", i, event_pulse);
            end
        end
        tick();
        checks++;
        if (event_pulse !== 1'b1 || cap_data !== 24'h000102 || cap_level !== 3'd1) begin
            errors++;
            $display("FAIL latency_capture: pulse=%b data=%h level=%0d want 1 000102 1",
                     event_pulse, cap_data, cap_level);
        end
        tick();
        checks++;
        if (event_pulse !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: pulse=%b want 0", event_pulse);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (cap_valid !== 1'b0 || cap_level !== 3'd0 || cap_data !== 24'd0) begin
            errors++;
            $display("FAIL pop_single: valid=%b level=%0d data=%h want 0 0 0",
                     cap_valid, cap_level, cap_data);
        end
    endtask

    task automatic test_both_edges();
        int pulses;
        logic [23:0] c0;
        edge_sel = 2'b00;
        evt_in   = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (cap_level !== 3'd0) begin
            errors++;
            $display("FAIL edge_off: level=%0d want 0", cap_level);
        end
        edge_sel = 2'b11;
        c0     = count_in;
        evt_in = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (event_pulse === 1'b1) pulses++;
        end
        evt_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (event_pulse === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 2 || cap_level !== 3'd2) begin
            errors++;
            $display("FAIL both_edges_count: pulses=%0d level=%0d want 2 2", pulses, cap_level);
        end
        checks++;
        if (cap_data !== c0 + 24'd2) begin
            errors++;
            $display("FAIL both_first: data=%h want %h", cap_data, c0 + 24'd2);
        end
        rd_en = 1'b1;
        tick();
        checks++;
        if (cap_data !== c0 + 24'd7) begin
            errors++;
            $display("FAIL both_second: data=%h want %h", cap_data, c0 + 24'd7);
        end
        tick();
        rd_en = 1'b0;
        checks++;
        if (cap_valid !== 1'b0) begin
            errors++;
            $display("FAIL both_drain: valid=%b want 0", cap_valid);
        end
        edge_sel = 2'b01;
    endtask

    task automatic test_overflow();
        int pulses;
        pulses = 0;
        for (int e = 0; e < 5; e++) begin
            vals[e] = count_in + 24'd2;
            evt_in  = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (event_pulse === 1'b1) pulses++;
            end
            evt_in = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (event_pulse === 1'b1) pulses++;
            end
        end
        checks++;
        if (pulses != 5 || cap_level !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: pulses=%0d level=%0d ovf=%b want 5 4 1",
                     pulses, cap_level, overflow);
        end
        checks++;
        if (cap_data !== vals[0]) begin
            errors++;
            $display("FAIL overflow_head: data=%h want %h", cap_data, vals[0]);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0 || cap_level !== 3'd4) begin
            errors++;
            $display("FAIL clr_ovf: ovf=%b level=%0d want 0 4", overflow, cap_level);
        end
    endtask

    task automatic test_full_with_read();
        newv   = count_in + 24'd2;
        evt_in = 1'b1;
        tick();
        tick();
        rd_en = 1'b1;
        tick();
        rd_en  = 1'b0;
        evt_in = 1'b0;
        checks++;
        if (event_pulse !== 1'b1 || cap_level !== 3'd4 || overflow !== 1'b0 ||
            cap_data !== vals[1]) begin
            errors++;
            $display("FAIL full_rw: pulse=%b level=%0d ovf=%b data=%h want 1 4 0 %h",
                     event_pulse, cap_level, overflow, cap_data, vals[1]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_data !== ((i < 3) ? vals[i+1] : newv)) begin
                errors++;
                $display("FAIL full_rw_order: entry %0d data=%h want %h", i, cap_data,
                         (i < 3) ? vals[i+1] : newv);
            end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (cap_level !== 3'd0 || cap_valid !== 1'b0 || cap_data !== 24'd0) begin
            errors++;
            $display("FAIL rd_empty: level=%0d valid=%b data=%h want 0 0 0",
                     cap_level, cap_valid, cap_data);
        end
    endtask

    task automatic test_reset_mid_and_arming();
        int pulses;
        // Fill, drop one, then pop one: three entries with overflow set.
        for (int e = 0; e < 5; e++) begin
            evt_in = 1'b1;
            for (int i = 0; i < 3; i++) tick();
            evt_in = 1'b0;
            for (int i = 0; i < 3; i++) tick();
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (cap_level !== 3'd3 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: level=%0d ovf=%b want 3 1", cap_level, overflow);
        end
        evt_in = 1'b1;
        reset  = 1'b0;
        tick();
        checks++;
        if (cap_level !== 3'd0 || cap_valid !== 1'b0 || overflow !== 1'b0 ||
            cap_data !== 24'd0) begin
            errors++;
            $display("FAIL mid_reset: level=%0d valid=%b ovf=%b data=%h want 0 0 0 0",
                     cap_level, cap_valid, overflow, cap_data);
        end
        tick();
        reset  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (event_pulse === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || cap_level !== 3'd0) begin
            errors++;
            $display("FAIL arming_spurious: pulses=%0d level=%0d want 0 0", pulses, cap_level);
        end
        evt_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (event_pulse === 1'b1) pulses++;
        end
        newv   = count_in + 24'd2;
        evt_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (event_pulse === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1 || cap_level !== 3'd1 || cap_data !== newv) begin
            errors++;
            $display("FAIL post_arm_capture: pulses=%0d level=%0d data=%h want 1 1 %h",
                     pulses, cap_level, cap_data, newv);
        end
    endtask

    initial begin
        reset    = 1'b0;
        count_in = 24'd0;
        evt_in   = 1'b0;
        edge_sel = 2'b01;
        rd_en    = 1'b0;
        clr_ovf  = 1'b0;
        test_reset();
        test_latency();
        test_both_edges();
        test_overflow();
        test_full_with_read();
        test_reset_mid_and_arming();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
